rope_collision_arbiter: RTL and testbench

Consumer end of the rope display interface. Watches per-pixel rope drawing requests against the monkey and screen-border drawing requests and accumulates overlaps over each frame. At every startOfFrame it returns one-cycle dirToggle and monkeyCollision pulses to the rope displays. It also runs an attach/release state machine that hands the attached rope's signed speed to the monkey movement logic.

---
 rtl/rope_pkg.sv | 20 ++
 rtl/rope_frame_latch.sv | 38 +++
 rtl/rope_collision_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_rope_collision_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rope_pkg.sv
// rope_pkg: shared types and widths for the rope collision arbiter.
// Used by rope_frame_latch and rope_collision_arbiter.
package rope_pkg;

    localparam int ROPES_DEFAULT = 6;
    localparam int LOCK_W        = 4;
    localparam int COOL_W        = 8;
    localparam int HCNT_W        = 8;

    typedef enum logic [1:0] {
        FREE     = 2'd0,
        ATTACHED = 2'd1,
        RELEASE  = 2'd2
    } rope_state_t;

    typedef logic signed [31:0] speed_t;

    typedef logic [ROPES_DEFAULT-1:0] rope_vec_t;

endpackage

// File: rtl/rope_frame_latch.sv
// rope_frame_latch: sticky per-rope monkey/border hit flags for one frame.
// At startOfFrame the flags restart from that pixel's own overlap.
module rope_frame_latch
    import rope_pkg::*;
#(
    parameter int N = ROPES_DEFAULT
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         startOfFrame,
    input  logic         monkeyDR,
    input  logic         borderDR,
    input  logic [N-1:0] ropeDR,
    output logic [N-1:0] hitMonkey,
    output logic [N-1:0] hitBorder
);

    logic [N-1:0] pix_m;
    logic [N-1:0] pix_b;

    assign pix_m = {N{monkeyDR}} & ropeDR;
    assign pix_b = {N{borderDR}} & ropeDR;

    // Accumulate overlaps; the register value is the frame snapshot at SOF.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hitMonkey <= '0;
            hitBorder <= '0;
        end else if (startOfFrame) begin
            hitMonkey <= pix_m;
            hitBorder <= pix_b;
        end else begin
            hitMonkey <= hitMonkey | pix_m;
            hitBorder <= hitBorder | pix_b;
        end
    end

endmodule

// File: rtl/rope_collision_arbiter.sv
// rope_collision_arbiter: per-frame rope/monkey/border collision evaluation.
// Optional macro ROPE_HIT_COUNT_EN adds saturating per-rope hitCount outputs.
module rope_collision_arbiter
    import rope_pkg::*;
#(
    parameter int ROPES           = ROPES_DEFAULT,
    parameter int LOCKOUT_FRAMES  = 4,
    parameter int COOLDOWN_FRAMES = 8,
    localparam int IW = (ROPES > 1) ? $clog2(ROPES) : 1
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startOfFrame,
    input  logic                   monkeyDR,
    input  logic                   borderDR,
    input  logic [ROPES-1:0]       ropeDR,
    input  logic [ROPES-1:0][31:0] SIGNED_SPEEDS,
    input  logic                   jumpReq,
    output logic [ROPES-1:0]       dirToggle,
    output logic [ROPES-1:0]       monkeyCollision,
    output logic                   attached,
    output logic [IW-1:0]          attachedIdx,
    output speed_t                 carrySpeed
`ifdef ROPE_HIT_COUNT_EN
    ,
    output logic [ROPES-1:0][HCNT_W-1:0] hitCount
`endif
);

    logic [ROPES-1:0]             hit_m;
    logic [ROPES-1:0]             hit_b;
    logic                         jump_seen;
    rope_state_t                  state;
    rope_state_t                  state_nxt;
    logic [IW-1:0]                idx;
    logic [IW-1:0]                idx_nxt;
    logic [COOL_W-1:0]            cool;
    logic [COOL_W-1:0]            cool_nxt;
    logic [ROPES-1:0]             coll_nxt;
    logic [ROPES-1:0]             tog_nxt;
    logic [ROPES-1:0][LOCK_W-1:0] lock;
    logic                         any_hit;
    logic [IW-1:0]                first_idx;

    rope_frame_latch #(
        .N(ROPES)
    ) u_latch (
        .clk         (clk),
        .resetN      (resetN),
        .startOfFrame(startOfFrame),
        .monkeyDR    (monkeyDR),
        .borderDR    (borderDR),
        .ropeDR      (ropeDR),
        .hitMonkey   (hit_m),
        .hitBorder   (hit_b)
    );

    // Jump requests are sticky over the frame, like the hit flags.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            jump_seen <= 1'b0;
        end else if (startOfFrame) begin
            jump_seen <= jumpReq;
        end else begin
            jump_seen <= jump_seen | jumpReq;
        end
    end

    // Fixed priority: lowest-numbered rope touching the monkey wins.
    always_comb begin
        any_hit   = |hit_m;
        first_idx = '0;
        for (int i = ROPES - 1; i >= 0; i--) begin
            if (hit_m[i]) begin
                first_idx = IW'(i);
            end
        end
    end

    // Direction toggles are gated by each rope's lockout counter.
    always_comb begin
        tog_nxt = '0;
        for (int i = 0; i < ROPES; i++) begin
            tog_nxt[i] = startOfFrame & hit_b[i] & (lock[i] == '0);
        end
    end

    // Attach/release FSM: next state and collision pulses, SOF only.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cool_nxt  = cool;
        coll_nxt  = '0;
        if (startOfFrame) begin
            unique case (state)
                FREE: begin
                    if (any_hit) begin
                        state_nxt           = ATTACHED;
                        idx_nxt             = first_idx;
                        coll_nxt[first_idx] = 1'b1;
                    end
                end
                ATTACHED: begin
                    if (jump_seen) begin
                        state_nxt = RELEASE;
                        cool_nxt  = COOL_W'(COOLDOWN_FRAMES);
                    end else if (!hit_m[idx]) begin
                        state_nxt = FREE;
                    end else begin
                        coll_nxt[idx] = 1'b1;
                    end
                end
                RELEASE: begin
                    if (cool == '0) begin
                        state_nxt = FREE;
                    end else begin
                        cool_nxt = cool - COOL_W'(1);
                    end
                end
                default: begin
                    state_nxt = FREE;
                end
            endcase
        end
    end

    // FSM registers plus registered evaluation pulses and carried speed.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state           <= FREE;
            idx             <= '0;
            cool            <= '0;
            dirToggle       <= '0;
            monkeyCollision <= '0;
            carrySpeed      <= '0;
        end else begin
            state           <= state_nxt;
            idx             <= idx_nxt;
            cool            <= cool_nxt;
            dirToggle       <= tog_nxt;
            monkeyCollision <= coll_nxt;
            if (state_nxt == ATTACHED) begin
                carrySpeed <= SIGNED_SPEEDS[idx_nxt];
            end else begin
                carrySpeed <= '0;
            end
        end
    end

    // Lockout counters: reload on toggle, else count down to zero per frame.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            lock <= '0;
        end else if (startOfFrame) begin
            for (int i = 0; i < ROPES; i++) begin
                if (tog_nxt[i]) begin
                    lock[i] <= LOCK_W'(LOCKOUT_FRAMES);
                end else if (lock[i] != '0) begin
                    lock[i] <= lock[i] - LOCK_W'(1);
                end
            end
        end
    end

`ifdef ROPE_HIT_COUNT_EN
    // Saturating per-rope monkey hit counters, advanced at each evaluation.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hitCount <= '0;
        end else if (startOfFrame) begin
            for (int i = 0; i < ROPES; i++) begin
                if (hit_m[i] && (hitCount[i] != {HCNT_W{1'b1}})) begin
                    hitCount[i] <= hitCount[i] + HCNT_W'(1);
                end
            end
        end
    end
`endif

    assign attached    = (state == ATTACHED);
    assign attachedIdx = idx;

endmodule

// File: tb/tb_rope_collision_arbiter.sv
// tb_rope_collision_arbiter: directed plan scenarios plus random frames,
// checked every cycle against a frame-level behavioural model.
module tb_rope_collision_arbiter;

    localparam int R    = 6;
    localparam int LOCK = 4;
    localparam int COOL = 8;

    typedef enum int {M_FREE, M_ATT, M_REL} mstate_e;

    logic                clk;
    logic                resetN;
    logic                startOfFrame;
    logic                monkeyDR;
    logic                borderDR;
    logic [R-1:0]        ropeDR;
    logic [R-1:0][31:0]  speeds;
    logic                jumpReq;
    logic [R-1:0]        dirToggle;
    logic [R-1:0]        monkeyCollision;
    logic                attached;
    logic [2:0]          attachedIdx;
    logic [31:0]         carrySpeed;
`ifdef ROPE_HIT_COUNT_EN
    logic [R-1:0][7:0]   hitCount;
`endif

    rope_collision_arbiter #(
        .ROPES          (R),
        .LOCKOUT_FRAMES (LOCK),
        .COOLDOWN_FRAMES(COOL)
    ) dut (
        .clk            (clk),
        .resetN         (resetN),
        .startOfFrame   (startOfFrame),
        .monkeyDR       (monkeyDR),
        .borderDR       (borderDR),
        .ropeDR         (ropeDR),
        .SIGNED_SPEEDS  (speeds),
        .jumpReq        (jumpReq),
        .dirToggle      (dirToggle),
        .monkeyCollision(monkeyCollision),
        .attached       (attached),
        .attachedIdx    (attachedIdx),
        .carrySpeed     (carrySpeed)
`ifdef ROPE_HIT_COUNT_EN
        ,
        .hitCount       (hitCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Frame-level model
    bit      mm[R];
    bit      mb[R];
    bit      mj;
    mstate_e m_st;
    int      m_idx;
    int      m_cool;
    int      m_lock[R];
    int      m_cnt[R];
    logic [R-1:0] exp_tog;
    logic [R-1:0] exp_coll;

    bit           rnd_speed;
    logic [R-1:0] cap_tog;
    logic [R-1:0] cap_coll;
    logic         cap_att;
    logic [2:0]   cap_idx;
    logic [31:0]  cap_carry;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < R; i++) begin
            mm[i] = 0; mb[i] = 0; m_lock[i] = 0; m_cnt[i] = 0;
        end
        mj = 0; m_st = M_FREE; m_idx = 0; m_cool = 0;
        exp_tog = '0; exp_coll = '0;
    endtask

    task automatic model_eval();
        int first;
        exp_tog  = '0;
        exp_coll = '0;
        for (int i = 0; i < R; i++) begin
            if (mb[i] && m_lock[i] == 0) begin
                exp_tog[i] = 1'b1;
                m_lock[i]  = LOCK;
            end else if (m_lock[i] > 0) begin
                m_lock[i]--;
            end
            if (mm[i] && m_cnt[i] < 255) m_cnt[i]++;
        end
        first = -1;
        for (int i = R - 1; i >= 0; i--) if (mm[i]) first = i;
        case (m_st)
            M_FREE: if (first >= 0) begin
                m_st = M_ATT; m_idx = first; exp_coll[first] = 1'b1;
            end
            M_ATT: begin
                if (mj) begin
                    m_st = M_REL; m_cool = COOL;
                end else if (!mm[m_idx]) begin
                    m_st = M_FREE;
                end else begin
                    exp_coll[m_idx] = 1'b1;
                end
            end
            default: begin
                if (m_cool == 0) m_st = M_FREE;
                else m_cool--;
            end
        endcase
    endtask

    task automatic px(input bit sof, input bit m, input bit b,
                      input logic [R-1:0] r, input bit j);
        logic [31:0] exp_carry;
        @(negedge clk);
        startOfFrame = sof; monkeyDR = m; borderDR = b;
        ropeDR = r; jumpReq = j;
        if (rnd_speed && $urandom_range(0, 7) == 0)
            speeds[$urandom_range(0, R - 1)] = $urandom;
        if (sof) begin
            model_eval();
            for (int i = 0; i < R; i++) begin
                mm[i] = m && r[i]; mb[i] = b && r[i];
            end
            mj = j;
        end else begin
            exp_tog = '0; exp_coll = '0;
            for (int i = 0; i < R; i++) begin
                mm[i] = mm[i] || (m && r[i]);
                mb[i] = mb[i] || (b && r[i]);
            end
            mj = mj || j;
        end
        @(posedge clk);
        #1;
        exp_carry = (m_st == M_ATT) ? speeds[m_idx] : 32'd0;
        chk("dirToggle", dirToggle, exp_tog);
        chk("monkeyCollision", monkeyCollision, exp_coll);
        chk("attached", attached, m_st == M_ATT);
        chk("attachedIdx", attachedIdx, m_idx[2:0]);
        chk("carrySpeed", carrySpeed, exp_carry);
`ifdef ROPE_HIT_COUNT_EN
        for (int i = 0; i < R; i++) chk("hitCount", hitCount[i], m_cnt[i]);
`endif
        if (sof) begin
            cap_tog = dirToggle; cap_coll = monkeyCollision;
            cap_att = attached; cap_idx = attachedIdx;
            cap_carry = carrySpeed;
        end
    endtask

    // SOF pixel, monkey on mr for 5 pixels, border on br, optional jump.
    task automatic frame(input logic [R-1:0] mr, input logic [R-1:0] br,
                         input bit jmp);
        px(1'b1, 1'b0, 1'b0, '0, 1'b0);
        for (int k = 1; k < 10; k++) begin
            if (k <= 5)      px(1'b0, mr != '0, 1'b0, mr, 1'b0);
            else if (k == 6) px(1'b0, 1'b0, br != '0, br, 1'b0);
            else             px(1'b0, 1'b0, 1'b0, '0, jmp && k == 7);
        end
    endtask

    task automatic rnd_frame();
        int len;
        len = $urandom_range(3, 14);
        px(1'b1, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
           R'($urandom), $urandom_range(0, 49) == 0);
        for (int k = 1; k < len; k++)
            px(1'b0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
               R'($urandom), $urandom_range(0, 49) == 0);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 resetN = 1'b0;
        #1;
        chk("rst_attached", attached, 0);
        chk("rst_carry", carrySpeed, 0);
        chk("rst_tog", dirToggle, 0);
        chk("rst_coll", monkeyCollision, 0);
        chk("rst_idx", attachedIdx, 0);
        model_reset();
        startOfFrame = 0; monkeyDR = 0; borderDR = 0;
        ropeDR = '0; jumpReq = 0;
        repeat (2) @(negedge clk);
        resetN = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int first;
        logic [5:0] hist;
        rnd_speed = 0;
        resetN = 0; startOfFrame = 0; monkeyDR = 0; borderDR = 0;
        ropeDR = '0; jumpReq = 0;
        for (int i = 0; i < R; i++) speeds[i] = 32'd100 + i;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_attached", attached, 0);
        chk("reset_carry", carrySpeed, 0);
        chk("reset_tog", dirToggle, 0);
        chk("reset_coll", monkeyCollision, 0);
        @(negedge clk);
        resetN = 1;

        // 1: idle frames
        for (int f = 0; f < 3; f++) begin
            frame('0, '0, 0);
            chk("t1_att", cap_att, 0);
            chk("t1_coll", cap_coll, 0);
            chk("t1_tog", cap_tog, 0);
        end

        // 2: attach to rope 2 with speed -3
        speeds[2] = 32'hFFFF_FFFD;
        frame(6'b000100, '0, 0);
        frame(6'b010010, '0, 0);
        chk("t2_coll", cap_coll, 6'b000100);
        chk("t2_att", cap_att, 1);
        chk("t2_idx", cap_idx, 2);
        chk("t2_carry", cap_carry, 32'hFFFF_FFFD);

        // 3: lowest-index priority, no switching
        frame(6'b010010, '0, 0);
        chk("t3_free", cap_att, 0);
        frame(6'b010000, '0, 0);
        chk("t3_idx", cap_idx, 1);
        chk("t3_coll", cap_coll, 6'b000010);
        frame('0, '0, 0);
        chk("t3_noswitch", cap_att, 0);
        chk("t3_nocoll", cap_coll, 0);

        // 4: border lockout
        hist = '0;
        for (int k = 0; k <= 6; k++) begin
            frame('0, (k < 6) ? 6'b000001 : 6'b000000, 0);
            if (k >= 1) hist[k-1] = cap_tog[0];
        end
        chk("t4_toggles", hist, 6'b100001);

        // 5: jump release and cooldown
        speeds[3] = 32'd7;
        frame(6'b001000, '0, 0);
        frame(6'b001000, '0, 1);
        chk("t5_att", cap_att, 1);
        chk("t5_idx", cap_idx, 3);
        chk("t5_carry", cap_carry, 7);
        frame(6'b001000, '0, 0);
        chk("t5_rel_att", cap_att, 0);
        chk("t5_rel_carry", cap_carry, 0);
        first = -1;
        for (int k = 1; k <= 12; k++) begin
            frame(6'b001000, '0, 0);
            if (cap_att && first < 0) first = k;
        end
        chk("t5_reattach", first, 10);

        // 6: async reset mid-frame while attached
        px(1'b0, 1'b1, 1'b1, 6'b001000, 1'b0);
        px(1'b0, 1'b1, 1'b1, 6'b001000, 1'b1);
        async_reset();
        frame('0, '0, 0);
        chk("t6_coll", cap_coll, 0);
        chk("t6_tog", cap_tog, 0);
        chk("t6_att", cap_att, 0);

        // random frames
        rnd_speed = 1;
        for (int f = 0; f < 200; f++) begin
            if (f == 100) begin
                px(1'b0, 1'b1, 1'b1, R'($urandom), 1'b0);
                async_reset();
            end
            rnd_frame();
        end
        px(1'b1, 1'b0, 1'b0, '0, 1'b0);
        px(1'b0, 1'b0, 1'b0, '0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
